// File: rtl/prom_buffer_arbiter_pkg.sv
// Shared definitions for the PROM buffer arbiter: default buffer geometry
// and the read-ownership tag that routes returning RAM data to its requester.
package prom_buffer_arbiter_pkg;

  localparam int PROM_DW = 16;
  localparam int PROM_AW = 10;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_ENG  = 2'd1,
    TAG_HOST = 2'd2
  } rd_tag_e;

endpackage

// File: rtl/prom_buffer_arbiter.sv
// Arbitrates a single-port buffer RAM between the engine (read/write) and the
// host (read-only); the engine wins conflicts until the host has starved STARVE_MAX times.
module prom_buffer_arbiter
  import prom_buffer_arbiter_pkg::*;
#(
  parameter int DW         = PROM_DW,
  parameter int AW         = PROM_AW,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ce,
  input  logic          eng_req,
  input  logic          eng_wr,
  input  logic [AW-1:0] eng_addr,
  input  logic [DW-1:0] eng_wdata,
  output logic          eng_gnt,
  output logic [DW-1:0] eng_rdata,
  output logic          eng_rvalid,
  input  logic          host_req,
  input  logic [AW-1:0] host_addr,
  output logic          host_gnt,
  output logic [DW-1:0] host_rdata,
  output logic          host_rvalid,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [15:0]   conflict_cnt
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  rd_tag_e       tag_reg, tag_next;
  logic [SW-1:0] starve_cnt_reg, starve_cnt_next;
  logic [15:0]   conflict_cnt_reg, conflict_cnt_next;
  logic [DW-1:0] eng_rdata_reg, host_rdata_reg;
  logic          conflict, host_force;

  always_comb begin
    conflict          = eng_req & host_req;
    host_force        = (starve_cnt_reg == STARVE_LIM);
    eng_gnt           = ce & eng_req & ~(host_req & host_force);
    host_gnt          = ce & host_req & (~eng_req | host_force);
    ram_en            = eng_gnt | host_gnt;
    ram_we            = eng_gnt & eng_wr;
    ram_addr          = '0;
    ram_wdata         = '0;
    tag_next          = TAG_NONE;
    starve_cnt_next   = starve_cnt_reg;
    conflict_cnt_next = conflict_cnt_reg;

    if (eng_gnt) begin
      ram_addr  = eng_addr;
      ram_wdata = eng_wdata;
      if (!eng_wr) tag_next = TAG_ENG;
    end else if (host_gnt) begin
      ram_addr = host_addr;
      tag_next = TAG_HOST;
    end

    if (host_gnt)
      starve_cnt_next = '0;
    else if (conflict && eng_gnt)
      starve_cnt_next = starve_cnt_reg + 1'b1;

    if (conflict && (conflict_cnt_reg != 16'hFFFF))
      conflict_cnt_next = conflict_cnt_reg + 16'd1;
  end

  // Returning data is valid while the tag is live in a ce-high cycle; the RAM
  // is not enabled while ce is low, so its output stays intact until then.
  assign eng_rvalid  = ce & (tag_reg == TAG_ENG);
  assign host_rvalid = ce & (tag_reg == TAG_HOST);
  assign eng_rdata   = eng_rvalid  ? ram_rdata : eng_rdata_reg;
  assign host_rdata  = host_rvalid ? ram_rdata : host_rdata_reg;
  assign conflict_cnt = conflict_cnt_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_reg          <= TAG_NONE;
      starve_cnt_reg   <= '0;
      conflict_cnt_reg <= '0;
      eng_rdata_reg    <= '0;
      host_rdata_reg   <= '0;
    end else if (ce) begin
      tag_reg          <= tag_next;
      starve_cnt_reg   <= starve_cnt_next;
      conflict_cnt_reg <= conflict_cnt_next;
      if (eng_rvalid)  eng_rdata_reg  <= ram_rdata;
      if (host_rvalid) host_rdata_reg <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_prom_buffer_arbiter.sv
// Directed bench for prom_buffer_arbiter with a behavioural single-port RAM.
module tb_prom_buffer_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ce;
  logic        eng_req, eng_wr;
  logic [9:0]  eng_addr;
  logic [15:0] eng_wdata;
  logic        eng_gnt;
  logic [15:0] eng_rdata;
  logic        eng_rvalid;
  logic        host_req;
  logic [9:0]  host_addr;
  logic        host_gnt;
  logic [15:0] host_rdata;
  logic        host_rvalid;
  logic        ram_en, ram_we;
  logic [9:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic [15:0] conflict_cnt;

  int n_checks = 0;
  int n_err    = 0;
  logic [15:0] exp_cc = 16'd0;

  always #5 clk = ~clk;

  prom_buffer_arbiter #(.DW(16), .AW(10), .STARVE_MAX(4)) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce),
    .eng_req(eng_req), .eng_wr(eng_wr), .eng_addr(eng_addr), .eng_wdata(eng_wdata),
    .eng_gnt(eng_gnt), .eng_rdata(eng_rdata), .eng_rvalid(eng_rvalid),
    .host_req(host_req), .host_addr(host_addr), .host_gnt(host_gnt),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .conflict_cnt(conflict_cnt)
  );

  // Behavioural buffer RAM: synchronous read, one cycle latency
  logic [15:0] mem [0:1023];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  typedef struct packed {
    logic        ce, er, ew;
    logic [9:0]  ea;
    logic [15:0] ed;
    logic        hr;
    logic [9:0]  ha;
    logic        eg, hg, en, we;
    logic [9:0]  ra;
    logic [15:0] rw;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic c, input logic er, input logic ew, input logic [9:0] ea,
                       input logic [15:0] ed, input logic hr, input logic [9:0] ha);
    ce = c; eng_req = er; eng_wr = ew; eng_addr = ea; eng_wdata = ed;
    host_req = hr; host_addr = ha;
  endtask

  // Advance one clock; the conflict counter model follows the driven inputs
  task automatic tick();
    if (reset_n && ce && eng_req && host_req && exp_cc != 16'hFFFF) exp_cc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 10'h0, 16'h0, 1'b0, 10'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_eng_rvalid", {31'd0, eng_rvalid}, 32'd0);
    chk("rst_host_rvalid", {31'd0, host_rvalid}, 32'd0);
    chk("rst_eng_rdata", {16'd0, eng_rdata}, 32'd0);
    chk("rst_host_rdata", {16'd0, host_rdata}, 32'd0);
    chk("rst_conflict_cnt", {16'd0, conflict_cnt}, 32'd0);
    ce = 1'b1;
    reset_n = 1'b1;
    #1;
    chk("release_no_gnt", {30'd0, eng_gnt, host_gnt}, 32'd0);
    $display("reset: eng_rvalid=%0b host_rvalid=%0b conflict_cnt=%0h", eng_rvalid, host_rvalid, conflict_cnt);
    @(posedge clk); #1;

    // ce er ew ea ed hr ha | eg hg en we ra rw
    tbl[0] = '{1'b1, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 16'h0000};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 10'h005, 16'h1234, 1'b0, 10'h000, 1'b1, 1'b0, 1'b1, 1'b1, 10'h005, 16'h1234};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b1, 10'h005, 1'b0, 1'b1, 1'b1, 1'b0, 10'h005, 16'h0000};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 10'h010, 16'h0000, 1'b0, 10'h000, 1'b1, 1'b0, 1'b1, 1'b0, 10'h010, 16'h0000};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 10'h011, 16'h5555, 1'b1, 10'h022, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 16'h0000};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 10'h003, 16'h0BEE, 1'b1, 10'h007, 1'b1, 1'b0, 1'b1, 1'b1, 10'h003, 16'h0BEE};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b1, 10'h3FF, 1'b0, 1'b1, 1'b1, 1'b0, 10'h3FF, 16'h0000};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 10'h3FF, 16'h0000, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 16'h0000};

    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].ce, tbl[i].er, tbl[i].ew, tbl[i].ea, tbl[i].ed, tbl[i].hr, tbl[i].ha);
      @(negedge clk);
      chk($sformatf("vec%0d_eng_gnt", i), {31'd0, eng_gnt}, {31'd0, tbl[i].eg});
      chk($sformatf("vec%0d_host_gnt", i), {31'd0, host_gnt}, {31'd0, tbl[i].hg});
      chk($sformatf("vec%0d_ram_en", i), {31'd0, ram_en}, {31'd0, tbl[i].en});
      chk($sformatf("vec%0d_ram_we", i), {31'd0, ram_we}, {31'd0, tbl[i].we});
      chk($sformatf("vec%0d_ram_addr", i), {22'd0, ram_addr}, {22'd0, tbl[i].ra});
      chk($sformatf("vec%0d_ram_wdata", i), {16'd0, ram_wdata}, {16'd0, tbl[i].rw});
      chk($sformatf("vec%0d_conflict_cnt", i), {16'd0, conflict_cnt}, {16'd0, exp_cc});
      $display("vec%0d: eng_gnt=%0b host_gnt=%0b ram_en=%0b ram_we=%0b addr=%0h wdata=%0h",
               i, eng_gnt, host_gnt, ram_en, ram_we, ram_addr, ram_wdata);
      tick();
    end

    // Engine write then host read of the same word
    drive(1'b1, 1'b1, 1'b1, 10'h005, 16'h1234, 1'b0, 10'h000);
    @(negedge clk); chk("wr5_eng_gnt", {31'd0, eng_gnt}, 32'd1);
    tick();
    drive(1'b1, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b1, 10'h005);
    @(negedge clk); chk("rd5_host_gnt", {31'd0, host_gnt}, 32'd1);
    tick();
    drive(1'b1, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 10'h000);
    @(negedge clk);
    chk("rd5_host_rvalid", {31'd0, host_rvalid}, 32'd1);
    chk("rd5_host_rdata", {16'd0, host_rdata}, 32'h1234);
    chk("rd5_eng_rvalid", {31'd0, eng_rvalid}, 32'd0);
    $display("wr/rd 0x005: host_rvalid=%0b host_rdata=%0h", host_rvalid, host_rdata);
    tick();
    @(negedge clk);
    chk("rd5_rvalid_pulse", {31'd0, host_rvalid}, 32'd0);
    chk("rd5_rdata_hold", {16'd0, host_rdata}, 32'h1234);

    // Back-to-back engine and host reads, separate data
    drive(1'b1, 1'b1, 1'b1, 10'h010, 16'h1111, 1'b0, 10'h000); tick();
    drive(1'b1, 1'b1, 1'b1, 10'h020, 16'h2222, 1'b0, 10'h000); tick();
    drive(1'b1, 1'b1, 1'b0, 10'h010, 16'h0000, 1'b0, 10'h000); tick();
    drive(1'b1, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b1, 10'h020);
    @(negedge clk);
    chk("b2b_host_gnt", {31'd0, host_gnt}, 32'd1);
    chk("b2b_eng_rvalid", {31'd0, eng_rvalid}, 32'd1);
    chk("b2b_eng_rdata", {16'd0, eng_rdata}, 32'h1111);
    chk("b2b_host_rvalid0", {31'd0, host_rvalid}, 32'd0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 10'h000);
    @(negedge clk);
    chk("b2b_host_rvalid", {31'd0, host_rvalid}, 32'd1);
    chk("b2b_host_rdata", {16'd0, host_rdata}, 32'h2222);
    chk("b2b_eng_rvalid0", {31'd0, eng_rvalid}, 32'd0);
    chk("b2b_eng_rdata_hold", {16'd0, eng_rdata}, 32'h1111);
    $display("b2b: eng_rdata=%0h host_rdata=%0h", eng_rdata, host_rdata);
    tick();

    // ce low for three cycles between a read grant and its return
    drive(1'b1, 1'b1, 1'b1, 10'h030, 16'h3333, 1'b0, 10'h000); tick();
    drive(1'b1, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b1, 10'h030);
    @(negedge clk); chk("ce_host_gnt", {31'd0, host_gnt}, 32'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 10'h040, 16'h0000, 1'b1, 10'h041);
      @(negedge clk);
      chk($sformatf("ce%0d_gnts", i), {30'd0, eng_gnt, host_gnt}, 32'd0);
      chk($sformatf("ce%0d_ram_en", i), {31'd0, ram_en}, 32'd0);
      chk($sformatf("ce%0d_host_rvalid", i), {31'd0, host_rvalid}, 32'd0);
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 10'h000);
    @(negedge clk);
    chk("ce_host_rvalid", {31'd0, host_rvalid}, 32'd1);
    chk("ce_host_rdata", {16'd0, host_rdata}, 32'h3333);
    $display("ce stall: host_rvalid=%0b host_rdata=%0h", host_rvalid, host_rdata);
    tick();

    // Continuous conflict: four engine wins then one forced host grant
    drive(1'b1, 1'b1, 1'b0, 10'h000, 16'h0000, 1'b1, 10'h001);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("stv%0d_eng_gnt", i), {31'd0, eng_gnt}, {31'd0, (i % 5) != 4});
      chk($sformatf("stv%0d_host_gnt", i), {31'd0, host_gnt}, {31'd0, (i % 5) == 4});
      chk($sformatf("stv%0d_conflict_cnt", i), {16'd0, conflict_cnt}, {16'd0, exp_cc});
      $display("starve cycle %0d: eng_gnt=%0b host_gnt=%0b conflict_cnt=%0h", i, eng_gnt, host_gnt, conflict_cnt);
      tick();
    end

    // Reset asserted the cycle after a host read grant
    drive(1'b1, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b1, 10'h020);
    @(negedge clk); chk("rr_host_gnt", {31'd0, host_gnt}, 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 10'h000);
    exp_cc = 16'd0;
    #1;
    chk("rr_host_rvalid", {31'd0, host_rvalid}, 32'd0);
    chk("rr_host_rdata", {16'd0, host_rdata}, 32'd0);
    chk("rr_eng_rdata", {16'd0, eng_rdata}, 32'd0);
    chk("rr_conflict_cnt", {16'd0, conflict_cnt}, 32'd0);
    chk("rr_ram_en", {31'd0, ram_en}, 32'd0);
    $display("reset mid-read: host_rvalid=%0b host_rdata=%0h conflict_cnt=%0h", host_rvalid, host_rdata, conflict_cnt);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("rr_post%0d_host_rvalid", i), {31'd0, host_rvalid}, 32'd0);
      chk($sformatf("rr_post%0d_gnts", i), {30'd0, eng_gnt, host_gnt}, 32'd0);
    end

    // Saturation after more than 65535 conflict cycles
    drive(1'b1, 1'b1, 1'b0, 10'h000, 16'h0000, 1'b1, 10'h001);
    for (int i = 0; i < 70000; i++) tick();
    chk("sat_conflict_cnt", {16'd0, conflict_cnt}, {16'd0, exp_cc});
    chk("sat_conflict_ffff", {16'd0, conflict_cnt}, 32'h0000FFFF);
    tick(); tick();
    chk("sat_conflict_hold", {16'd0, conflict_cnt}, 32'h0000FFFF);
    $display("saturation: conflict_cnt=%0h", conflict_cnt);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
